mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Sequential load/store access unit between the multicycle datapath and the word-wide data memory. Given a load or store of byte, halfword or word size at an arbitrary byte address, it runs the memory handshake, including read-modify-write for sub-word stores. It selects the addressed byte lane and sign- or zero-extends loaded data, and flags misaligned accesses without touching memory. It replaces the purely combinational load-size selection stage and is the single point through which the control unit issues data-memory accesses.

## Interface
- MEM_LAT, 1: synchronous memory read latency in cycles (legal 1..4)
- ADDR_W, 32: byte address width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears FSM and all registered outputs
- start  in  1  request strobe, sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, valid in the low bits for the access size
- busy  out  1  high from the cycle after an accepted start until and including DONE
- done  out  1  one-cycle completion pulse
- misalign  out  1  valid with done; 1 = access aborted
- rdata  out  32  extended load result, held until next accepted start
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2], 2'b00}
- mem_wr  out  1  write enable, high for exactly one cycle per write
- mem_wdata  out  32  merged write word
- mem_rdata  in  32  memory read data

## Operation
- Reset values: busy 0, done 0, misalign 0, rdata 0, mem_addr 0, mem_wr 0, mem_wdata 0; FSM in IDLE.
- Request fields (is_store, size, sign_ext, addr, wdata) are latched on the accepting edge. Later input changes have no effect.
- Misaligned: size 11, half with addr[0]=1, or word with addr[1:0]≠00. This path issues no memory access and leaves rdata unchanged.
- Little-endian lanes. Byte k = addr[1:0] occupies bits [8k+7:8k]. The half is bits [15:0] when addr[1]=0 and [31:16] when addr[1]=1.
- Load: the selected lane is extended to 32 bits by sign_ext. A word load returns mem_rdata unchanged.
- Word store: mem_wdata = wdata.
- Sub-word store: the current word is read, the selected lane is replaced by wdata[7:0] or wdata[15:0], and the merged word is written back. All other bytes are preserved.
- FSM states:
  - IDLE: on start, misaligned requests go to ERR. Loads and sub-word stores go to READ. Word stores go to WRITE.
  - READ: lasts MEM_LAT cycles, counted by a down-counter. On the last cycle mem_rdata is captured. Loads then go to DONE, sub-word stores to WRITE.
  - WRITE: one cycle with mem_wr=1, then DONE.
  - ERR: one cycle, then DONE with misalign=1.
  - DONE: one cycle with done=1, then IDLE.
- start while busy is ignored and not queued. start in the DONE cycle is also ignored.
- reset asserted in any state returns the FSM to IDLE at that edge. A pending write is abandoned and mem_wr is 0 from the following cycle.

## Timing
- Accepting edge = E0. mem_addr is valid from E0 and is stable until return to IDLE.
- Load: READ covers cycles E0..E0+MEM_LAT-1. rdata is updated and done=1 in cycle E0+MEM_LAT. Latency is MEM_LAT+1 cycles from start to done.
- Word store: mem_wr=1 in cycle E0, done in cycle E0+1.
- Sub-word store: READ for MEM_LAT cycles, mem_wr=1 in cycle E0+MEM_LAT, done in E0+MEM_LAT+1.
- Misaligned: ERR in cycle E0, done=1 and misalign=1 in E0+1. mem_wr is never asserted.
- Back-to-back: the earliest next accept is the cycle after DONE.

## Test plan
- Reset then idle: all outputs are 0 and start is ignored while reset=1. After release, a word load at 0x100 with mem[0x100]=0xDEADBEEF gives rdata=0xDEADBEEF and done one cycle after MEM_LAT.
- Byte load at 0x103 with mem word 0x80FF7F01: sign_ext=1 gives rdata=0xFFFFFF80; sign_ext=0 gives 0x00000080. Half load at 0x102 with sign_ext=1 gives 0xFFFF80FF.
- Byte store of 0xAB at 0x201 over mem word 0x11223344 leaves mem[0x200]=0x1122AB44. Check exactly one mem_wr pulse, in cycle E0+MEM_LAT.
- Misaligned half at 0x301, misaligned word at 0x302, and size=11: each gives done with misalign=1, no mem_wr, and rdata unchanged.
- start pulsed every cycle during a load: only the first request executes, and the next accept occurs only after DONE.
- Reset asserted during READ of a sub-word store: no mem_wr is issued, memory is unchanged, and the FSM returns to IDLE. Repeat with MEM_LAT=1 and MEM_LAT=3.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store access unit between the multicycle datapath and a word-wide data memory.
// Handles byte/half/word lanes, sign/zero extension, read-modify-write stores and misalignment.
module mem_access_unit #(
   parameter int MEM_LAT = 1,
   parameter int ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              is_store_i,
   input  logic [1:0]        size_i,
   input  logic              sign_ext_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              misalign_o,
   output logic [31:0]       rdata_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, ERR, DONE} state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] LAT_M1  = 2'(MEM_LAT - 1);

   state_e            state_q, state_d;
   logic [1:0]        cnt_q;
   logic              is_store_q, sign_ext_q, err_q;
   logic [1:0]        size_q, lane_q;
   logic [15:0]       wdata_q;
   logic [31:0]       rdata_q, mem_wdata_q;
   logic [ADDR_W-1:0] mem_addr_q;

   logic        accept, mis_req, word_store;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_ext, merged;

   assign accept     = (state_q == IDLE) && start_i;
   assign word_store = is_store_i && (size_i == SZ_WORD);
   assign mis_req    = (size_i == 2'b11) ||
                       ((size_i == SZ_HALF) && addr_i[0]) ||
                       ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start_i) begin
            if (mis_req)         state_d = ERR;
            else if (word_store) state_d = WRITE;
            else                 state_d = READ;
         end
         READ:    if (cnt_q == 2'd0) state_d = is_store_q ? WRITE : DONE;
         WRITE:   state_d = DONE;
         ERR:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy_o     = (state_q != IDLE);
      done_o     = (state_q == DONE);
      misalign_o = (state_q == DONE) && err_q;
      mem_wr_o   = (state_q == WRITE);
   end

   // Lane selection for loads and lane merge for sub-word stores
   always_comb begin
      rd_byte  = mem_rdata_i[{lane_q, 3'b000} +: 8];
      rd_half  = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];
      load_ext = mem_rdata_i;
      if (size_q == SZ_BYTE)      load_ext = {{24{sign_ext_q & rd_byte[7]}}, rd_byte};
      else if (size_q == SZ_HALF) load_ext = {{16{sign_ext_q & rd_half[15]}}, rd_half};
      merged = mem_rdata_i;
      if (size_q == SZ_BYTE) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else                   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q       <= '0;
         is_store_q  <= 1'b0;
         sign_ext_q  <= 1'b0;
         err_q       <= 1'b0;
         size_q      <= '0;
         lane_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mem_wdata_q <= '0;
         mem_addr_q  <= '0;
      end else if (accept) begin
         cnt_q      <= LAT_M1;
         is_store_q <= is_store_i;
         sign_ext_q <= sign_ext_i;
         err_q      <= mis_req;
         size_q     <= size_i;
         lane_q     <= addr_i[1:0];
         wdata_q    <= wdata_i[15:0];
         mem_addr_q <= {addr_i[ADDR_W-1:2], 2'b00};
         if (word_store) mem_wdata_q <= wdata_i;
      end else if (state_q == READ) begin
         // The final READ cycle is the one where mem_rdata is valid
         if (cnt_q != 2'd0)   cnt_q       <= cnt_q - 2'd1;
         else if (is_store_q) mem_wdata_q <= merged;
         else                 rdata_q     <= load_ext;
      end
   end

   assign rdata_o     = rdata_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_addr_o  = mem_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: two instances (MEM_LAT 1 and 3) share stimulus,
// each with its own word memory model; a vector table plus hand-written corner sequences.
module tb_mem_access_unit;

   typedef struct {
      logic        is_store;
      logic [1:0]  size;
      logic        sign_ext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic        chk_rd;
      logic [31:0] exp_rdata;
      logic [31:0] exp_mem;
      logic        exp_mis;
   } vec_t;

   localparam int LAT [2] = '{1, 3};

   logic clk = 1'b0;
   logic reset, start, is_store, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   logic [1:0]  busy, done, misalign, mem_wr;
   logic [31:0] rdata [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic [31:0] mem [2][256];

   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx;
   logic [31:0] pl_val;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_LAT(1), .ADDR_W(32)) u_lat1 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .is_store_i(is_store),
      .size_i(size), .sign_ext_i(sign_ext), .addr_i(addr), .wdata_i(wdata),
      .busy_o(busy[0]), .done_o(done[0]), .misalign_o(misalign[0]), .rdata_o(rdata[0]),
      .mem_addr_o(mem_addr[0]), .mem_wr_o(mem_wr[0]), .mem_wdata_o(mem_wdata[0]),
      .mem_rdata_i(mem_rdata[0])
   );

   mem_access_unit #(.MEM_LAT(3), .ADDR_W(32)) u_lat3 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .is_store_i(is_store),
      .size_i(size), .sign_ext_i(sign_ext), .addr_i(addr), .wdata_i(wdata),
      .busy_o(busy[1]), .done_o(done[1]), .misalign_o(misalign[1]), .rdata_o(rdata[1]),
      .mem_addr_o(mem_addr[1]), .mem_wr_o(mem_wr[1]), .mem_wdata_o(mem_wdata[1]),
      .mem_rdata_i(mem_rdata[1])
   );

   // Memory model: address is held stable through READ, so the read port is combinational
   assign mem_rdata[0] = mem[0][mem_addr[0][9:2]];
   assign mem_rdata[1] = mem[1][mem_addr[1][9:2]];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (pl_en)          mem[k][pl_idx] <= pl_val;
         else if (mem_wr[k]) mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      pl_idx = idx;
      pl_val = val;
      pl_en  = 1'b1;
      @(posedge clk);
      #1 pl_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic drive_req(input logic st, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] wd);
      start    = 1'b1;
      is_store = st;
      size     = sz;
      sign_ext = sx;
      addr     = a;
      wdata    = wd;
   endtask

   task automatic run_op(input int row, input vec_t v);
      int nd [2], dc [2], nw [2], wc [2];
      logic mis [2];
      logic [31:0] rd [2];
      logic [31:0] ma [2];
      int exp_dc;
      preload(v.addr[9:2], v.init);
      drive_req(v.is_store, v.size, v.sign_ext, v.addr, v.wdata);
      @(negedge clk);
      // Scramble the request fields after the accepting edge; they must have been latched
      drive_req(~v.is_store, ~v.size, ~v.sign_ext, ~v.addr, ~v.wdata);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         nd[k] = 0; dc[k] = -1; nw[k] = 0; wc[k] = -1; mis[k] = 1'b0; rd[k] = '0;
         ma[k] = mem_addr[k];
      end
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (done[k]) begin
               nd[k]++;
               if (dc[k] < 0) begin dc[k] = c; mis[k] = misalign[k]; rd[k] = rdata[k]; end
            end
            if (mem_wr[k]) begin
               nw[k]++;
               if (wc[k] < 0) wc[k] = c;
            end
         end
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         string tag;
         tag = $sformatf("row%0d lat%0d", row, LAT[k]);
         if (v.exp_mis || (v.is_store && v.size == 2'b10)) exp_dc = 1;
         else if (v.is_store)                               exp_dc = LAT[k] + 1;
         else                                               exp_dc = LAT[k];
         check({tag, " mem_addr"}, ma[k], {v.addr[31:2], 2'b00});
         check({tag, " done_cycle"}, 32'(dc[k]), 32'(exp_dc));
         check({tag, " done_pulses"}, 32'(nd[k]), 32'd1);
         check({tag, " misalign"}, {31'd0, mis[k]}, {31'd0, v.exp_mis});
         if (v.chk_rd) check({tag, " rdata"}, rd[k], v.exp_rdata);
         check({tag, " mem_word"}, mem[k][v.addr[9:2]], v.exp_mem);
         if (v.is_store && !v.exp_mis) begin
            check({tag, " wr_pulses"}, 32'(nw[k]), 32'd1);
            check({tag, " wr_cycle"}, 32'(wc[k]),
                  (v.size == 2'b10) ? 32'd0 : 32'(LAT[k]));
         end else begin
            check({tag, " wr_pulses"}, 32'(nw[k]), 32'd0);
         end
      end
   endtask

   vec_t vecs [13];

   initial begin
      int first_done [2];
      logic b1 [2], b2 [2];
      logic [31:0] rd1 [2];
      int nw [2];

      //        st    sz     sx    addr           wdata          init           chk  exp_rdata      exp_mem        mis
      vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         32'h80FF_7F01, 1'b1, 32'hFFFF_FF80, 32'h80FF_7F01, 1'b0};
      vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         32'h80FF_7F01, 1'b1, 32'h0000_0080, 32'h80FF_7F01, 1'b0};
      vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         32'h80FF_7F01, 1'b1, 32'hFFFF_80FF, 32'h80FF_7F01, 1'b0};
      vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,         32'h80FF_7F01, 1'b1, 32'h0000_7F01, 32'h80FF_7F01, 1'b0};
      vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,         32'h80FF_7F01, 1'b1, 32'h0000_007F, 32'h80FF_7F01, 1'b0};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0301, 32'h0,         32'h0123_4567, 1'b1, 32'h0000_007F, 32'h0123_4567, 1'b1};
      vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0302, 32'hFFFF_FFFF, 32'h0123_4567, 1'b1, 32'h0000_007F, 32'h0123_4567, 1'b1};
      vecs[8]  = '{1'b0, 2'b11, 1'b1, 32'h0000_0300, 32'h0,         32'h0123_4567, 1'b1, 32'h0000_007F, 32'h0123_4567, 1'b1};
      vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00AB, 32'h1122_3344, 1'b0, 32'h0,         32'h1122_AB44, 1'b0};
      vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_BEEF, 32'h1122_3344, 1'b0, 32'h0,         32'hBEEF_3344, 1'b0};
      vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[12] = '{1'b1, 2'b00, 1'b0, 32'h0000_0207, 32'hFFFF_FF55, 32'hAABB_CCDD, 1'b0, 32'h0,         32'h55BB_CCDD, 1'b0};

      // Reset held with start asserted: nothing moves
      reset = 1'b1;
      drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("reset ctl lat%0d", LAT[k]),
                  {28'd0, busy[k], done[k], misalign[k], mem_wr[k]}, 32'd0);
            check($sformatf("reset rdata lat%0d", LAT[k]), rdata[k], 32'd0);
            check($sformatf("reset mem_addr lat%0d", LAT[k]), mem_addr[k], 32'd0);
            check($sformatf("reset mem_wdata lat%0d", LAT[k]), mem_wdata[k], 32'd0);
         end
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         check($sformatf("idle after reset lat%0d", LAT[k]), {31'd0, busy[k]}, 32'd0);

      for (int i = 0; i < 13; i++) run_op(i, vecs[i]);

      // start held high during a load: only the first request runs, next accept after DONE
      preload(8'h40, 32'hDEAD_BEEF);
      preload(8'h41, 32'h1357_9BDF);
      drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
      @(negedge clk);
      addr = 32'h0000_0104;
      for (int k = 0; k < 2; k++) begin
         first_done[k] = -1; b1[k] = 1'b0; b2[k] = 1'b0; rd1[k] = '0;
      end
      for (int c = 0; c < 12; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (done[k] && first_done[k] < 0) begin first_done[k] = c; rd1[k] = rdata[k]; end
            if (first_done[k] >= 0 && c == first_done[k] + 1) b1[k] = busy[k];
            if (first_done[k] >= 0 && c == first_done[k] + 2) b2[k] = busy[k];
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("spam done_cycle lat%0d", LAT[k]), 32'(first_done[k]), 32'(LAT[k]));
         check($sformatf("spam first rdata lat%0d", LAT[k]), rd1[k], 32'hDEAD_BEEF);
         check($sformatf("spam idle after done lat%0d", LAT[k]), {31'd0, b1[k]}, 32'd0);
         check($sformatf("spam reaccept lat%0d", LAT[k]), {31'd0, b2[k]}, 32'd1);
         check($sformatf("spam last rdata lat%0d", LAT[k]), rdata[k], 32'h1357_9BDF);
      end

      // Reset during READ of a byte store: write abandoned, memory untouched
      preload(8'h80, 32'h1122_3344);
      drive_req(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00AB);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) nw[k] = mem_wr[k] ? 1 : 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < 2; k++) if (mem_wr[k] || done[k]) nw[k]++;
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_read no wr/done lat%0d", LAT[k]), 32'(nw[k]), 32'd0);
         check($sformatf("rst_read mem lat%0d", LAT[k]), mem[k][8'h80], 32'h1122_3344);
         check($sformatf("rst_read idle lat%0d", LAT[k]), {31'd0, busy[k]}, 32'd0);
      end

      // Unit still operates after the abort
      run_op(13, '{1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0, 32'h1122_3344, 1'b1,
                   32'h0000_0033, 32'h1122_3344, 1'b0});

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
